// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, one power-of-two shift per stage,
// with a valid/ready output handshake that stalls the whole pipe at once.
module pipe_shifter #(
  parameter int WIDTH = 16,
  localparam int S = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [S-1:0]     shift_val,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out,
  output logic             zero,
  output logic             mode_err
);

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;

  logic             valid_reg [S];
  logic [WIDTH-1:0] data_reg  [S];
  logic [2:0]       mode_reg  [S];
  logic             carry_reg [S];
  logic [S-1:0]     amt_reg   [S-1];

  logic             valid_cur [S];
  logic [WIDTH-1:0] data_cur  [S];
  logic [2:0]       mode_cur  [S];
  logic             carry_cur [S];
  logic [S-1:0]     amt_cur   [S];

  logic [WIDTH-1:0] data_next  [S];
  logic             carry_next [S];

  logic en;

  assign en       = !out_valid || out_ready;
  // Reset must never back-pressure the source, even with a stalled result.
  assign in_ready = en || rst;

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : stg
      localparam int SH = 1 << gi;

      logic [WIDTH-1:0] d_nx;
      logic             c_nx;

      if (gi == 0) begin : src
        assign valid_cur[gi] = in_valid;
        assign data_cur[gi]  = shift_in;
        assign mode_cur[gi]  = mode;
        assign carry_cur[gi] = 1'b0;
        assign amt_cur[gi]   = shift_val;
      end else begin : src
        assign valid_cur[gi] = valid_reg[gi-1];
        assign data_cur[gi]  = data_reg[gi-1];
        assign mode_cur[gi]  = mode_reg[gi-1];
        assign carry_cur[gi] = carry_reg[gi-1];
        assign amt_cur[gi]   = amt_reg[gi-1];
      end

      // The last stage that actually shifts determines the final carry, so each active stage overwrites it.
      always_comb begin
        d_nx = data_cur[gi];
        c_nx = carry_cur[gi];
        if (amt_cur[gi][gi]) begin
          case (mode_cur[gi])
            MODE_SLL: begin
              d_nx = data_cur[gi] << SH;
              c_nx = data_cur[gi][WIDTH-SH];
            end
            MODE_SRL: begin
              d_nx = data_cur[gi] >> SH;
              c_nx = data_cur[gi][SH-1];
            end
            MODE_SRA: begin
              d_nx = $unsigned($signed(data_cur[gi]) >>> SH);
              c_nx = data_cur[gi][SH-1];
            end
            MODE_ROR: begin
              d_nx = {data_cur[gi][SH-1:0], data_cur[gi][WIDTH-1:SH]};
              c_nx = data_cur[gi][SH-1];
            end
            MODE_ROL: begin
              d_nx = {data_cur[gi][WIDTH-SH-1:0], data_cur[gi][WIDTH-1:WIDTH-SH]};
              c_nx = data_cur[gi][WIDTH-SH];
            end
            default: begin
              d_nx = data_cur[gi];
              c_nx = carry_cur[gi];
            end
          endcase
        end
      end

      assign data_next[gi]  = d_nx;
      assign carry_next[gi] = c_nx;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        valid_reg[k] <= 1'b0;
        data_reg[k]  <= '0;
        mode_reg[k]  <= '0;
        carry_reg[k] <= 1'b0;
      end
      for (int k = 0; k < S - 1; k++) begin
        amt_reg[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < S; k++) begin
        valid_reg[k] <= valid_cur[k];
        data_reg[k]  <= data_next[k];
        mode_reg[k]  <= mode_cur[k];
        carry_reg[k] <= carry_next[k];
      end
      for (int k = 0; k < S - 1; k++) begin
        amt_reg[k] <= amt_cur[k];
      end
    end
  end

  assign out_valid = valid_reg[S-1];
  assign shift_out = data_reg[S-1];
  assign carry_out = carry_reg[S-1];
  assign mode_err  = (mode_reg[S-1] > MODE_ROL);
  assign zero      = (shift_out == '0);

endmodule
